// File: rtl/i2c_spartan_slave_responder_pkg.sv
// ---------------------------------------------------------------------------
// i2c_slave_pkg
// Shared definitions for the Spartan 3E I2C slave responder:
//   state_t           protocol state encoding
//   MODE_SLAVE_*      transfer direction taken from the address R/W bit
//   RAM_DEPTH/RAM_AW  geometry of the local register RAM
// ---------------------------------------------------------------------------
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    REG      = 3'd3,
    WDATA    = 3'd4,
    RDATA    = 3'd5,
    RACK     = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  localparam logic MODE_SLAVE_WRITE = 1'b0;
  localparam logic MODE_SLAVE_READ  = 1'b1;

  localparam int RAM_DEPTH = 32;
  localparam int RAM_AW    = 5;

endpackage

// File: rtl/i2c_spartan_slave_responder_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Brings the raw SCL/SDA pins into the clk domain and decodes bus events.
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   scl_i, sda_i    raw pin levels
//   sda_o           synchronized SDA, aligned with the event pulses below
//   scl_rise_o      one-cycle pulse on an SCL rising edge
//   scl_fall_o      one-cycle pulse on an SCL falling edge
//   start_o         one-cycle pulse: SDA fell while SCL was high
//   stop_o          one-cycle pulse: SDA rose while SCL was high
// Pin-to-pulse latency is 3 clk (two synchronizer stages + edge register).
// ---------------------------------------------------------------------------
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q;

  // Synchronizer and edge registers. The line flops reset to 1 (idle bus)
  // so that leaving reset never fakes an edge, START or STOP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
      scl_rise_q <= scl_sync_q & ~scl_prev_q;
      scl_fall_q <= ~scl_sync_q & scl_prev_q;
      start_q    <= ~sda_sync_q & sda_prev_q & scl_sync_q & scl_prev_q;
      stop_q     <= sda_sync_q & ~sda_prev_q & scl_sync_q & scl_prev_q;
    end
  end

  assign sda_o      = sda_prev_q;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_spartan_slave_responder.sv
// ---------------------------------------------------------------------------
// i2c_spartan_slave_responder
// Oversampled I2C slave fronting the 32x8 LCD/menu register RAM. After an
// address match it takes a pointer byte, then either writes incoming bytes
// to the RAM or streams RAM bytes back, auto-incrementing the pointer.
// Ports:
//   clk, reset         system clock (>=10x SCL), asynchronous active-low reset
//   SCL_IN, SDA_IN     raw bus pin levels
//   SDA_OE             1 pulls SDA low, 0 releases it
//   RAM_ADD            register pointer / RAM address
//   RAM_DIN, RAM_W     RAM write data and one-cycle write strobe
//   RAM_RDOUT          RAM read data (1 clk after RAM_ADD)
//   Slave_Busy         addressed transaction in progress
//   Slave_WriteDone    pulse on STOP closing a transaction that wrote data
// ---------------------------------------------------------------------------
module i2c_spartan_slave_responder
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCL_IN,
  input  logic              SDA_IN,
  output logic              SDA_OE,
  output logic [RAM_AW-1:0] RAM_ADD,
  output logic [7:0]        RAM_DIN,
  output logic              RAM_W,
  input  logic [7:0]        RAM_RDOUT,
  output logic              Slave_Busy,
  output logic              Slave_WriteDone
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              ack_q, ack_d;
  logic              mode_q, mode_d;
  logic              sda_oe_q, sda_oe_d;
  logic [3:0]        hold_q, hold_d;
  logic [RAM_AW-1:0] ram_add_q, ram_add_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic              ram_w_q, ram_w_d;
  logic              busy_q, busy_d;
  logic              wrote_q, wrote_d;
  logic              wdone_q, wdone_d;
  logic [7:0]        byte_in;
  logic              drive;

  i2c_line_sync u_line_sync (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (SCL_IN),
    .sda_i      (SDA_IN),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  assign byte_in = {shift_q[6:0], sda_s};

  // Level SDA should take during the current SCL low phase: ACK slots pull
  // low, read data drives the inverted MSB of the shifter, all else releases.
  always_comb begin
    drive = 1'b0;
    if (state_q == ADDR_ACK || ack_q) begin
      drive = 1'b1;
    end else if (state_q == RDATA) begin
      drive = ~shift_q[7];
    end
  end

  // State register for the whole responder.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ack_q     <= 1'b0;
      mode_q    <= MODE_SLAVE_WRITE;
      sda_oe_q  <= 1'b0;
      hold_q    <= '0;
      ram_add_q <= '0;
      ram_din_q <= '0;
      ram_w_q   <= 1'b0;
      busy_q    <= 1'b0;
      wrote_q   <= 1'b0;
      wdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ack_q     <= ack_d;
      mode_q    <= mode_d;
      sda_oe_q  <= sda_oe_d;
      hold_q    <= hold_d;
      ram_add_q <= ram_add_d;
      ram_din_q <= ram_din_d;
      ram_w_q   <= ram_w_d;
      busy_q    <= busy_d;
      wrote_q   <= wrote_d;
      wdone_q   <= wdone_d;
    end
  end

  // Next-state logic. STOP outranks START, which outranks SCL bit events,
  // so a STOP coinciding with an SCL edge always ends the transaction.
  // SDA_OE only moves when the hold timer, armed by an SCL falling edge,
  // expires; START/STOP bypass it to release the line at once.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ack_d     = ack_q;
    mode_d    = mode_q;
    sda_oe_d  = sda_oe_q;
    hold_d    = hold_q;
    ram_add_d = ram_add_q;
    ram_din_d = ram_din_q;
    ram_w_d   = 1'b0;
    busy_d    = busy_q;
    wrote_d   = wrote_q;
    wdone_d   = 1'b0;

    if (ram_w_q) begin
      ram_add_d = ram_add_q + 5'd1;
    end

    if (hold_q != 4'd0) begin
      hold_d = hold_q - 4'd1;
      if (hold_q == 4'd1) begin
        sda_oe_d = drive;
      end
    end
    if (scl_fall) begin
      hold_d = HOLD_LOAD;
    end

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      hold_d    = '0;
      bit_cnt_d = '0;
      ack_d     = 1'b0;
      busy_d    = 1'b0;
      wdone_d   = wrote_q;
      wrote_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      hold_d    = '0;
      bit_cnt_d = '0;
      ack_d     = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              mode_d  = byte_in[0];
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          bit_cnt_d = '0;
          if (mode_q == MODE_SLAVE_READ) begin
            state_d = RDATA;
            shift_d = RAM_RDOUT;
          end else begin
            state_d = REG;
          end
        end
        REG, WDATA: begin
          if (ack_q) begin
            ack_d   = 1'b0;
            state_d = WDATA;
          end else begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_d = 1'b1;
              if (state_q == REG) begin
                ram_add_d = byte_in[RAM_AW-1:0];
              end else begin
                ram_din_d = byte_in;
                ram_w_d   = 1'b1;
                wrote_d   = 1'b1;
              end
            end
          end
        end
        RDATA: begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d   = RACK;
            ram_add_d = ram_add_q + 5'd1;
          end
        end
        RACK: begin
          bit_cnt_d = '0;
          if (!sda_s) begin
            state_d = RDATA;
            shift_d = RAM_RDOUT;
          end else begin
            state_d = IGNORE;
            busy_d  = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign SDA_OE          = sda_oe_q;
  assign RAM_ADD         = ram_add_q;
  assign RAM_DIN         = ram_din_q;
  assign RAM_W           = ram_w_q;
  assign Slave_Busy      = busy_q;
  assign Slave_WriteDone = wdone_q;

endmodule

// File: tb/tb_i2c_spartan_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_spartan_slave_responder
// Bus-master model plus RAM model around the I2C slave responder. Expected
// RAM writes are queued as bytes are sent and checked by a monitor process
// that fires on every RAM_W strobe.
// ---------------------------------------------------------------------------
module tb_i2c_spartan_slave_responder;

  localparam int Q = 100;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclM = 1'b1;
  logic       sdaM = 1'b1;
  logic       sdaLine;
  logic       sdaOe;
  logic [4:0] ramAdd;
  logic [7:0] ramDin;
  logic       ramW;
  logic [7:0] ramRdout = 8'h00;
  logic       slaveBusy;
  logic       writeDone;

  logic [7:0] mem [32];
  wr_t        expQ [$];

  int checkCount = 0;
  int passCount = 0;
  int ackCount = 0;
  int writeCount = 0;
  int wdoneCount = 0;
  int oeViolations = 0;
  logic oeSeen = 1'b0;
  logic busySeen = 1'b0;
  logic prevRamW = 1'b0;
  logic prevOe = 1'b0;

  assign sdaLine = sdaM & ~sdaOe;

  i2c_spartan_slave_responder dut (
    .clk             (clk),
    .reset           (reset),
    .SCL_IN          (sclM),
    .SDA_IN          (sdaLine),
    .SDA_OE          (sdaOe),
    .RAM_ADD         (ramAdd),
    .RAM_DIN         (ramDin),
    .RAM_W           (ramW),
    .RAM_RDOUT       (ramRdout),
    .Slave_Busy      (slaveBusy),
    .Slave_WriteDone (writeDone)
  );

  // 100 MHz-style system clock; SCL runs at 40 clk per bit.
  always #5 clk = ~clk;

  // Local register RAM with one clock of read latency.
  always @(posedge clk) ramRdout <= mem[ramAdd];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every RAM_W strobe pops one expected write and is
  // also applied to the RAM model. Also tracks WriteDone pulses and any
  // SDA_OE assertion while SCL is high.
  always @(negedge clk) begin
    if (ramW) begin
      writeCount++;
      checkOutput("ram_w_width", {31'd0, prevRamW}, 32'd0);
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_ram_w: got addr 0x%0h data 0x%0h, expected none",
                 ramAdd, ramDin);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("ram_w_addr", {27'd0, ramAdd}, {27'd0, e.addr});
        checkOutput("ram_w_data", {24'd0, ramDin}, {24'd0, e.data});
      end
      mem[ramAdd] = ramDin;
    end
    if (writeDone) wdoneCount++;
    if (sdaOe && !prevOe && sclM) oeViolations++;
    if (sdaOe) oeSeen = 1'b1;
    if (slaveBusy) busySeen = 1'b1;
    prevRamW = ramW;
    prevOe = sdaOe;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic sdaVal, input logic sclVal);
    sdaM = sdaVal;
    sclM = sclVal;
    #Q;
  endtask

  task automatic startCond();
    applyStimulus(1'b1, sclM);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic stopCond();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
  endtask

  task automatic sendBit(input logic b, output logic lineVal);
    applyStimulus(b, 1'b0);
    applyStimulus(b, 1'b1);
    lineVal = sdaLine;
    applyStimulus(b, 1'b1);
    applyStimulus(b, 1'b0);
  endtask

  task automatic writeByte(input logic [7:0] b, input logic expectAck, input string name);
    logic lineVal;
    for (int i = 7; i >= 0; i--) sendBit(b[i], lineVal);
    sendBit(1'b1, lineVal);
    if (!lineVal) ackCount++;
    checkOutput(name, {31'd0, ~lineVal}, {31'd0, expectAck});
  endtask

  task automatic readByte(input logic nack, input logic [7:0] expected, input string name);
    logic       lineVal;
    logic [7:0] got;
    got = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sendBit(1'b1, lineVal);
      got[i] = lineVal;
    end
    sendBit(nack, lineVal);
    checkOutput(name, {24'd0, got}, {24'd0, expected});
  endtask

  task automatic pushWrite(input logic [4:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  initial begin
    int wBase;
    int dBase;
    logic lineVal;
    logic [7:0] wrapData [3];

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_sda_oe", {31'd0, sdaOe}, 32'd0);
    checkOutput("reset_ram_add", {27'd0, ramAdd}, 32'd0);
    checkOutput("reset_ram_w", {31'd0, ramW}, 32'd0);
    checkOutput("reset_busy", {31'd0, slaveBusy}, 32'd0);
    checkOutput("reset_wdone", {31'd0, writeDone}, 32'd0);
    reset = 1'b1;
    #(2 * Q);

    $display("[TB] write burst 0x00..0x1F from pointer 0");
    ackCount = 0;
    wBase = writeCount;
    dBase = wdoneCount;
    startCond();
    writeByte(8'h84, 1'b1, "burst_addr_ack");
    checkOutput("burst_busy", {31'd0, slaveBusy}, 32'd1);
    writeByte(8'h00, 1'b1, "burst_reg_ack");
    for (int i = 0; i < 32; i++) begin
      pushWrite(5'(i), 8'(i));
      writeByte(8'(i), 1'b1, "burst_data_ack");
    end
    stopCond();
    checkOutput("burst_ack_count", ackCount, 34);
    checkOutput("burst_writes", writeCount - wBase, 32);
    checkOutput("burst_wdone", wdoneCount - dBase, 1);
    checkOutput("burst_busy_after_stop", {31'd0, slaveBusy}, 32'd0);
    checkOutput("burst_queue_empty", expQ.size(), 0);
    checkOutput("burst_ram_add_wrapped", {27'd0, ramAdd}, 32'd0);

    $display("[TB] pointer wrap 30,31,0");
    wrapData[0] = 8'hAA;
    wrapData[1] = 8'hBB;
    wrapData[2] = 8'hCC;
    wBase = writeCount;
    dBase = wdoneCount;
    startCond();
    writeByte(8'h84, 1'b1, "wrap_addr_ack");
    writeByte(8'h1E, 1'b1, "wrap_reg_ack");
    pushWrite(5'd30, wrapData[0]);
    writeByte(wrapData[0], 1'b1, "wrap_data_ack");
    pushWrite(5'd31, wrapData[1]);
    writeByte(wrapData[1], 1'b1, "wrap_data_ack");
    pushWrite(5'd0, wrapData[2]);
    writeByte(wrapData[2], 1'b1, "wrap_data_ack");
    stopCond();
    checkOutput("wrap_writes", writeCount - wBase, 3);
    checkOutput("wrap_wdone", wdoneCount - dBase, 1);
    checkOutput("wrap_ram_add", {27'd0, ramAdd}, 32'd1);

    $display("[TB] read 3 bytes from pointer 5 via repeated START");
    wBase = writeCount;
    dBase = wdoneCount;
    startCond();
    writeByte(8'h84, 1'b1, "read_addr_w_ack");
    writeByte(8'h05, 1'b1, "read_reg_ack");
    startCond();
    writeByte(8'h85, 1'b1, "read_addr_r_ack");
    readByte(1'b0, 8'h05, "read_byte0");
    readByte(1'b0, 8'h06, "read_byte1");
    readByte(1'b1, 8'h07, "read_byte2");
    checkOutput("read_sda_released", {31'd0, sdaOe}, 32'd0);
    checkOutput("read_busy_after_nack", {31'd0, slaveBusy}, 32'd0);
    checkOutput("read_ram_add", {27'd0, ramAdd}, 32'd8);
    stopCond();
    checkOutput("read_no_writes", writeCount - wBase, 0);
    checkOutput("read_no_wdone", wdoneCount - dBase, 0);

    $display("[TB] address mismatch 0x90");
    wBase = writeCount;
    oeSeen = 1'b0;
    busySeen = 1'b0;
    startCond();
    writeByte(8'h90, 1'b0, "mm_addr_nack");
    writeByte(8'h00, 1'b0, "mm_reg_nack");
    stopCond();
    checkOutput("mm_oe_never", {31'd0, oeSeen}, 32'd0);
    checkOutput("mm_busy_never", {31'd0, busySeen}, 32'd0);
    checkOutput("mm_no_writes", writeCount - wBase, 0);

    $display("[TB] STOP after 4 data bits");
    wBase = writeCount;
    dBase = wdoneCount;
    startCond();
    writeByte(8'h84, 1'b1, "mid_addr_ack");
    writeByte(8'h10, 1'b1, "mid_reg_ack");
    sendBit(1'b1, lineVal);
    sendBit(1'b0, lineVal);
    sendBit(1'b1, lineVal);
    sendBit(1'b0, lineVal);
    stopCond();
    checkOutput("mid_no_writes", writeCount - wBase, 0);
    checkOutput("mid_no_wdone", wdoneCount - dBase, 0);
    checkOutput("mid_sda_released", {31'd0, sdaOe}, 32'd0);
    checkOutput("mid_busy", {31'd0, slaveBusy}, 32'd0);
    checkOutput("mid_ram_add", {27'd0, ramAdd}, 32'h10);

    $display("[TB] reset asserted mid-ADDR");
    startCond();
    writeByte(8'h84, 1'b1, "rst_addr_ack");
    startCond();
    sendBit(1'b1, lineVal);
    sendBit(1'b0, lineVal);
    sendBit(1'b0, lineVal);
    sendBit(1'b0, lineVal);
    checkOutput("rst_busy_before", {31'd0, slaveBusy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst_sda_oe", {31'd0, sdaOe}, 32'd0);
    checkOutput("rst_ram_add", {27'd0, ramAdd}, 32'd0);
    checkOutput("rst_busy", {31'd0, slaveBusy}, 32'd0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1);

    wBase = writeCount;
    dBase = wdoneCount;
    startCond();
    writeByte(8'h84, 1'b1, "post_rst_addr_ack");
    writeByte(8'h03, 1'b1, "post_rst_reg_ack");
    pushWrite(5'd3, 8'h5A);
    writeByte(8'h5A, 1'b1, "post_rst_data_ack");
    stopCond();
    checkOutput("post_rst_writes", writeCount - wBase, 1);
    checkOutput("post_rst_wdone", wdoneCount - dBase, 1);

    #(4 * Q);
    checkOutput("oe_while_scl_high", oeViolations, 0);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
